// File: rtl/div_result_buffer_pkg.sv
// -----------------------------------------------------------------------------
// div_result_buffer_pkg
// Shared definitions for the divider result path. The upstream divider wrapper
// and div_result_buffer both import this package so the result layout and the
// default sizing stay in one place.
//   DIV_N_DEFAULT      default operand/result width
//   DIV_DEPTH_DEFAULT  default result FIFO depth (power of two, >= 2)
//   div_result_t       one divider result {quotient, remainder} at default width
//   count_width()      width of an occupancy counter that can hold 0..depth
// -----------------------------------------------------------------------------
package div_result_buffer_pkg;

  localparam int DIV_N_DEFAULT     = 32;
  localparam int DIV_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [DIV_N_DEFAULT-1:0] quotient;
    logic [DIV_N_DEFAULT-1:0] remainder;
  } div_result_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/div_credit_counter.sv
// -----------------------------------------------------------------------------
// div_credit_counter
// Tracks divider operations that have been started but not yet completed and
// grants issue credit so that in-flight plus buffered results never exceed the
// result FIFO depth.
//   clk, rst     clock / asynchronous active-high reset
//   i_issue      upstream started a divide this cycle
//   i_done       divider produced a result this cycle
//   i_count      registered FIFO occupancy from the parent
//   o_issue_ok   upstream may start a divide (decoded from registers only)
//   o_err        single-cycle pulse: issue without credit, or done with
//                nothing in flight
// -----------------------------------------------------------------------------
module div_credit_counter
  import div_result_buffer_pkg::*;
#(
  parameter int DEPTH = DIV_DEPTH_DEFAULT,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_issue,
  input  logic          i_done,
  input  logic [CW-1:0] i_count,
  output logic          o_issue_ok,
  output logic          o_err
);

  // One spare bit: illegal issues are still counted, so inflight can exceed
  // DEPTH. The counter saturates rather than wrapping if abuse continues.
  localparam int IW = CW + 1;
  localparam logic [IW-1:0] INFLIGHT_MAX = '1;
  localparam logic [IW:0]   DEPTH_W      = (IW+1)'(DEPTH);

  logic [IW-1:0] r_inflight;
  logic [IW-1:0] w_inflight_next;
  logic [IW:0]   w_committed;

  // Both operands are registers, so issue_ok has no path from any input.
  assign w_committed = {1'b0, r_inflight} + {2'b00, i_count};
  assign o_issue_ok  = (w_committed < DEPTH_W);

  assign o_err = (i_issue && !o_issue_ok) || (i_done && (r_inflight == '0));

  always_comb begin
    w_inflight_next = r_inflight;
    if (i_issue && !i_done) begin
      if (r_inflight != INFLIGHT_MAX) begin
        w_inflight_next = r_inflight + IW'(1);
      end
    end else if (!i_issue && i_done) begin
      // A spurious done must not wrap the counter below zero.
      if (r_inflight != '0) begin
        w_inflight_next = r_inflight - IW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      r_inflight <= w_inflight_next;
    end
  end

endmodule

// File: rtl/div_result_buffer.sv
// -----------------------------------------------------------------------------
// div_result_buffer
// Credit-controlled FIFO that collects {quotient, remainder} results from a
// divider and hands them downstream with a valid/ready handshake.
//   clk, rst                       clock / asynchronous active-high reset
//   issue, issue_ok                upstream start and start credit
//   div_done, div_quotient,
//   div_remainder                  divider result strobe and data
//   m_valid, m_ready,
//   m_quotient, m_remainder        downstream head-of-queue handshake (data
//                                  registered, no same-cycle bypass)
//   count                          FIFO occupancy
//   protocol_err                   sticky flag for any protocol violation
// -----------------------------------------------------------------------------
module div_result_buffer
  import div_result_buffer_pkg::*;
#(
  parameter int N     = DIV_N_DEFAULT,
  parameter int DEPTH = DIV_DEPTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue,
  output logic                       issue_ok,
  input  logic                       div_done,
  input  logic [N-1:0]               div_quotient,
  input  logic [N-1:0]               div_remainder,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [N-1:0]               m_quotient,
  output logic [N-1:0]               m_remainder,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       protocol_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  // Same layout as div_result_t, sized to this instance's width.
  typedef struct packed {
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
  } entry_t;

  entry_t        r_mem [DEPTH];
  entry_t        r_head;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  entry_t        w_wr_entry;
  entry_t        w_head_next;
  logic [PW-1:0] w_wr_ptr_next;
  logic [PW-1:0] w_rd_ptr_next;
  logic [CW-1:0] w_count_next;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_push_drop;
  logic          w_credit_err;

  div_credit_counter #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .i_issue    (issue),
    .i_done     (div_done),
    .i_count    (r_count),
    .o_issue_ok (issue_ok),
    .o_err      (w_credit_err)
  );

  assign w_wr_entry = {div_quotient, div_remainder};

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pop       = (r_count != '0) && m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push      = div_done && (!w_full || w_pop);
  assign w_push_drop = div_done && !w_push;

  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_count_next  = r_count;
    if (w_push) begin
      w_wr_ptr_next = r_wr_ptr + PW'(1);
    end
    if (w_pop) begin
      w_rd_ptr_next = r_rd_ptr + PW'(1);
    end
    if (w_push && !w_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  // Head register: loaded with the entry that will be at the front next cycle.
  // When the incoming result itself becomes the head (FIFO empty, or one entry
  // leaving while one arrives) the array still holds stale data at that slot,
  // so the write data is forwarded. When the FIFO goes empty the last value is
  // held, which keeps the outputs at zero until the first push after reset.
  always_comb begin
    w_head_next = r_head;
    if (w_count_next != '0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
        w_head_next = w_wr_entry;
      end else begin
        w_head_next = r_mem[w_rd_ptr_next];
      end
    end
  end

  // Storage array is never reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      r_err    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
      r_err    <= r_err | w_credit_err | w_push_drop;
    end
  end

  assign m_valid      = (r_count != '0);
  assign m_quotient   = r_head.quotient;
  assign m_remainder  = r_head.remainder;
  assign count        = r_count;
  assign protocol_err = r_err;

endmodule

// File: tb/tb_div_result_buffer.sv
module tb_div_result_buffer;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          issue;
  logic          issue_ok;
  logic          div_done;
  logic [N-1:0]  div_quotient;
  logic [N-1:0]  div_remainder;
  logic          m_valid;
  logic          m_ready;
  logic [N-1:0]  m_quotient;
  logic [N-1:0]  m_remainder;
  logic [CW-1:0] count;
  logic          protocol_err;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
  } res_t;

  res_t exp_q[$];   // results pushed into the DUT, not yet popped
  res_t ops[$];     // operations issued, divider not yet done
  res_t cur;

  int checks   = 0;
  int failures = 0;
  int n_pop    = 0;
  int bp_start;
  int bp_issued;
  int bp_cyc;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;

  logic         stall;
  logic [N-1:0] held_q;
  logic [N-1:0] held_r;

  always #5 clk = ~clk;

  div_result_buffer #(
    .N     (N),
    .DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .issue         (issue),
    .issue_ok      (issue_ok),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_quotient    (m_quotient),
    .m_remainder   (m_remainder),
    .count         (count),
    .protocol_err  (protocol_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a divider completion this cycle; the result is expected downstream.
  task automatic send_done(input logic [N-1:0] q, input logic [N-1:0] r);
    res_t e;
    div_done      = 1'b1;
    div_quotient  = q;
    div_remainder = r;
    e.q = q;
    e.r = r;
    exp_q.push_back(e);
  endtask

  // One clock: score a handshake happening at this edge, then advance to #1
  // after the edge and confirm a stalled head did not move.
  task automatic tick();
    res_t e;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", m_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        $display("pop %0d q=0x%08h r=0x%08h exp_q=0x%08h exp_r=0x%08h",
                 n_pop, m_quotient, m_remainder, e.q, e.r);
        chk("m_quotient", m_quotient, e.q);
        chk("m_remainder", m_remainder, e.r);
      end
    end
    stall  = m_valid && !m_ready;
    held_q = m_quotient;
    held_r = m_remainder;
    @(posedge clk);
    #1;
    if (stall) begin
      chk("stall_valid", m_valid, 1'b1);
      chk("stall_quotient", m_quotient, held_q);
      chk("stall_remainder", m_remainder, held_r);
    end
  endtask

  // Asynchronous reset pulse between edges, with immediate output checks.
  task automatic pulse_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    ops.delete();
    stall = 1'b0;
    chk({tag, "_m_valid"}, m_valid, 1'b0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_issue_ok"}, issue_ok, 1'b1);
    chk({tag, "_protocol_err"}, protocol_err, 1'b0);
    chk({tag, "_m_quotient"}, m_quotient, 0);
    chk({tag, "_m_remainder"}, m_remainder, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    issue         = 1'b0;
    div_done      = 1'b0;
    div_quotient  = '0;
    div_remainder = '0;
    m_ready       = 1'b0;
    stall         = 1'b0;
    held_q        = '0;
    held_r        = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_issue_ok", issue_ok, 1'b1);
    chk("rst_protocol_err", protocol_err, 1'b0);
    chk("rst_m_quotient", m_quotient, 0);
    chk("rst_m_remainder", m_remainder, 0);
    rst = 1'b0;
    tick();

    // Single op: 100/7 -> q=14 r=2
    issue = 1'b1;
    tick();
    issue = 1'b0;
    chk("single_issue_ok", issue_ok, 1'b1);
    send_done(32'd14, 32'd2);
    m_ready = 1'b1;
    tick();
    div_done = 1'b0;
    chk("single_valid_next", m_valid, 1'b1);
    chk("single_count1", count, 1);
    tick();
    chk("single_count0", count, 0);
    chk("single_valid_off", m_valid, 1'b0);

    // Back-to-back: four issues exhaust credit, four dones fill the FIFO
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1;
      tick();
    end
    issue = 1'b0;
    chk("b2b_issue_ok_low", issue_ok, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send_done(32'd100 + 32'(i), 32'(i));
      tick();
    end
    div_done = 1'b0;
    chk("b2b_count_full", count, 4);
    chk("b2b_issue_ok_full", issue_ok, 1'b0);
    chk("b2b_protocol_err", protocol_err, 1'b0);
    m_ready = 1'b1;
    tick();
    chk("b2b_count3", count, 3);
    chk("b2b_issue_ok_back", issue_ok, 1'b1);
    repeat (3) tick();
    chk("b2b_drained", count, 0);

    // Random backpressure over 200 results, divide-by-zero mixed in
    bp_start  = n_pop;
    bp_issued = 0;
    bp_cyc    = 0;
    while (((n_pop - bp_start) < 200) && (bp_cyc < 20000)) begin
      bp_cyc++;
      div_done = 1'b0;
      if ((ops.size() > 0) && ($urandom_range(0, 1) == 1)) begin
        cur = ops.pop_front();
        send_done(cur.q, cur.r);
      end
      issue = 1'b0;
      if ((bp_issued < 200) && issue_ok && ($urandom_range(0, 2) != 0)) begin
        dividend = $urandom;
        divisor  = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom_range(1, 1000));
        if (divisor == '0) begin
          cur.q = '1;
          cur.r = dividend;
        end else begin
          cur.q = dividend / divisor;
          cur.r = dividend % divisor;
        end
        ops.push_back(cur);
        bp_issued++;
        issue = 1'b1;
      end
      m_ready = 1'($urandom_range(0, 1));
      tick();
      chk("bp_count", count, exp_q.size());
      chk("bp_issue_ok", issue_ok, (ops.size() + exp_q.size()) < DEPTH);
    end
    div_done = 1'b0;
    issue    = 1'b0;
    chk("bp_results", n_pop - bp_start, 200);
    chk("bp_protocol_err", protocol_err, 1'b0);

    // Full with simultaneous push and pop. Credit caps inflight+count at 4, so
    // with count=4 nothing is in flight and this done is itself a credit
    // violation: protocol_err is expected from that, while the push and pop
    // both still take effect.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1;
      tick();
    end
    issue = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_done(32'h0000_0A00 + 32'(i), 32'h0000_0B00 + 32'(i));
      tick();
    end
    div_done = 1'b0;
    chk("full_count", count, 4);
    chk("full_err_before", protocol_err, 1'b0);
    send_done(32'h0000_0A04, 32'h0000_0B04);
    m_ready = 1'b1;
    tick();
    div_done = 1'b0;
    m_ready  = 1'b0;
    chk("full_simul_count", count, 4);
    chk("full_head_adv", m_quotient, exp_q[0].q);
    chk("full_simul_err", protocol_err, 1'b1);

    // Push while full with no pop: dropped, contents unchanged
    div_done      = 1'b1;
    div_quotient  = 32'hDEAD_BEEF;
    div_remainder = 32'hFEED_F00D;
    tick();
    div_done = 1'b0;
    chk("drop_count", count, 4);
    m_ready = 1'b1;
    repeat (4) tick();
    m_ready = 1'b0;
    chk("drop_drained", count, 0);
    chk("drop_valid_off", m_valid, 1'b0);

    // Violation: issue without credit, flag is sticky
    pulse_reset("rst1");
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1;
      tick();
    end
    chk("viol_err_clean", protocol_err, 1'b0);
    tick();
    issue = 1'b0;
    chk("viol_issue_err", protocol_err, 1'b1);
    repeat (3) tick();
    chk("viol_issue_sticky", protocol_err, 1'b1);

    // Violation: done with nothing in flight, result still stored
    pulse_reset("rst2");
    send_done(32'd7, 32'd3);
    tick();
    div_done = 1'b0;
    chk("viol_done_err", protocol_err, 1'b1);
    chk("viol_done_count", count, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("viol_done_sticky", protocol_err, 1'b1);
    chk("viol_done_drained", count, 0);

    // Reset mid-stream with count=3, inflight=2
    pulse_reset("rst3");
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1;
      tick();
    end
    issue = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_done(32'h0000_0C00 + 32'(i), 32'(i));
      tick();
    end
    div_done = 1'b0;
    issue    = 1'b1;
    tick();
    issue = 1'b0;
    chk("mid_count3", count, 3);
    pulse_reset("rst_mid");
    m_ready = 1'b1;
    repeat (4) tick();
    chk("mid_no_stale", m_valid, 1'b0);
    issue = 1'b1;
    tick();
    issue = 1'b0;
    send_done(32'h0000_0055, 32'h0000_0001);
    tick();
    div_done = 1'b0;
    chk("mid_fresh_valid", m_valid, 1'b1);
    tick();
    chk("mid_fresh_drained", count, 0);
    chk("mid_fresh_err", protocol_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
